// File: rtl/suspect_str_ast_tx.sv
// Streams a latched string out as an Avalon-ST packet, S symbols per beat.
// Optional packet counter compiled in with `define SUSPECT_STR_AST_TX_CNT_EN.
module suspect_str_ast_tx #(
  parameter int BYTE_W             = 8,
  parameter int MAX_STR_SIZE       = 16,
  parameter int AST_SOURCE_SYMBOLS = 8,
  parameter int AST_SOURCE_ORDER   = 1,
  parameter int AST_SOURCE_EMPTY_W = (AST_SOURCE_SYMBOLS == 1) ? 1 : $clog2(AST_SOURCE_SYMBOLS),
  parameter int LEN_W              = $clog2(MAX_STR_SIZE) + 1,
  parameter int CNT_W              = 32
) (
  input  logic                                 clk_i,
  input  logic                                 srst_n_i,
  input  logic [MAX_STR_SIZE*BYTE_W-1:0]       str_data_i,
  input  logic [LEN_W-1:0]                     str_len_i,
  input  logic                                 str_valid_i,
  output logic                                 str_ready_o,
  output logic [AST_SOURCE_SYMBOLS*BYTE_W-1:0] ast_source_data_o,
  input  logic                                 ast_source_ready_i,
  output logic                                 ast_source_valid_o,
  output logic [AST_SOURCE_EMPTY_W-1:0]        ast_source_empty_o,
  output logic                                 ast_source_startofpacket_o,
  output logic                                 ast_source_endofpacket_o,
  output logic [CNT_W-1:0]                     sent_cnt_o,
  input  logic                                 sent_cnt_clean_stb_i
);

  localparam int S = AST_SOURCE_SYMBOLS;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          state, state_nxt;
  logic [MAX_STR_SIZE*BYTE_W-1:0]  str_q;
  logic [LEN_W-1:0]                len_q;
  logic [LEN_W-1:0]                beat_q;

  logic                            len_ok;
  logic                            take;
  logic                            beat_acc;
  logic                            eop_acc;

  logic [MAX_STR_SIZE*BYTE_W-1:0]  src_str;
  logic [LEN_W-1:0]                src_len;
  logic [LEN_W-1:0]                src_beat;
  logic [S*BYTE_W-1:0]             nxt_data;
  logic                            nxt_sop;
  logic                            nxt_eop;
  logic [AST_SOURCE_EMPTY_W-1:0]   nxt_empty;

  assign str_ready_o = (state == IDLE);
  assign len_ok      = (str_len_i != '0) && (str_len_i <= LEN_W'(MAX_STR_SIZE));
  assign take        = str_valid_i && str_ready_o && len_ok;
  // valid is high for the whole of SEND, so ready alone accepts a beat
  assign beat_acc    = (state == SEND) && ast_source_ready_i;
  assign eop_acc     = beat_acc && ast_source_endofpacket_o;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take)    state_nxt = SEND;
      SEND:    if (eop_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next beat: beat 0 of the incoming string in IDLE, else the following beat of the held one
  always_comb begin
    int nbeats;
    int pos;
    int sel;
    int elem;
    src_str  = (state == IDLE) ? str_data_i : str_q;
    src_len  = (state == IDLE) ? str_len_i  : len_q;
    src_beat = (state == IDLE) ? '0 : beat_q + LEN_W'(1);
    nbeats   = (int'(src_len) + S - 1) / S;
    nxt_data = '0;
    for (int j = 0; j < S; j++) begin
      pos  = int'(src_beat) * S + j;
      sel  = (pos < MAX_STR_SIZE) ? pos : 0;
      elem = (AST_SOURCE_ORDER == 1) ? (S - 1 - j) : j;
      if (pos < int'(src_len))
        nxt_data[elem*BYTE_W +: BYTE_W] = src_str[sel*BYTE_W +: BYTE_W];
    end
    nxt_sop   = (src_beat == '0);
    nxt_eop   = (int'(src_beat) == nbeats - 1);
    nxt_empty = nxt_eop ? AST_SOURCE_EMPTY_W'(nbeats * S - int'(src_len)) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      str_q                      <= '0;
      len_q                      <= '0;
      beat_q                     <= '0;
      ast_source_valid_o         <= 1'b0;
      ast_source_data_o          <= '0;
      ast_source_startofpacket_o <= 1'b0;
      ast_source_endofpacket_o   <= 1'b0;
      ast_source_empty_o         <= '0;
    end else if (state == IDLE) begin
      if (take) begin
        str_q                      <= str_data_i;
        len_q                      <= str_len_i;
        beat_q                     <= '0;
        ast_source_valid_o         <= 1'b1;
        ast_source_data_o          <= nxt_data;
        ast_source_startofpacket_o <= nxt_sop;
        ast_source_endofpacket_o   <= nxt_eop;
        ast_source_empty_o         <= nxt_empty;
      end
    end else if (beat_acc) begin
      if (ast_source_endofpacket_o) begin
        beat_q                     <= '0;
        ast_source_valid_o         <= 1'b0;
        ast_source_data_o          <= '0;
        ast_source_startofpacket_o <= 1'b0;
        ast_source_endofpacket_o   <= 1'b0;
        ast_source_empty_o         <= '0;
      end else begin
        beat_q                     <= beat_q + LEN_W'(1);
        ast_source_data_o          <= nxt_data;
        ast_source_startofpacket_o <= nxt_sop;
        ast_source_endofpacket_o   <= nxt_eop;
        ast_source_empty_o         <= nxt_empty;
      end
    end
  end

`ifdef SUSPECT_STR_AST_TX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i)                      cnt_q <= '0;
    else if (sent_cnt_clean_stb_i)      cnt_q <= '0;
    else if (eop_acc && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign sent_cnt_o = cnt_q;
`else
  logic unused_clean;
  assign unused_clean = sent_cnt_clean_stb_i;
  assign sent_cnt_o   = '0;
`endif

endmodule

// File: doc/suspect_str_ast_tx.md
SUSPECT_STR_AST_TX -- requirements
Module: suspect_str_ast_tx

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, bits per symbol.
REQ-002 SHALL have parameter MAX_STR_SIZE, default 16, maximum string length in bytes.
REQ-003 SHALL have parameter AST_SOURCE_SYMBOLS, default 8, symbols per beat (>=1).
REQ-004 SHALL have parameter AST_SOURCE_ORDER, default 1: 1 puts the first symbol in the high-order bits, 0 in the low-order bits.
REQ-005 SHALL have parameter AST_SOURCE_EMPTY_W, derived: 1 if AST_SOURCE_SYMBOLS==1, else $clog2(AST_SOURCE_SYMBOLS).
REQ-006 SHALL have parameter LEN_W, derived: $clog2(MAX_STR_SIZE)+1.
REQ-007 SHALL have parameter CNT_W, default 32, packet counter width.
REQ-008 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-009 srst_n_i  input  1  synchronous reset, active-low.
REQ-010 str_data_i  input  MAX_STR_SIZE*BYTE_W  suspect string; element 0 is the first character.
REQ-011 str_len_i  input  LEN_W  string length in bytes.
REQ-012 str_valid_i  input  1  string offered.
REQ-013 str_ready_o  output  1  string accepted when high together with str_valid_i.
REQ-014 ast_source_data_o  output  AST_SOURCE_SYMBOLS*BYTE_W  Avalon-ST data.
REQ-015 ast_source_ready_i  input  1  Avalon-ST ready, readyLatency 0.
REQ-016 ast_source_valid_o  output  1  Avalon-ST valid.
REQ-017 ast_source_empty_o  output  AST_SOURCE_EMPTY_W  number of unused symbols; meaningful only on the end-of-packet beat.
REQ-018 ast_source_startofpacket_o  output  1  first beat of a packet.
REQ-019 ast_source_endofpacket_o  output  1  last beat of a packet.
REQ-020 sent_cnt_o  output  CNT_W  count of packets sent.
REQ-021 sent_cnt_clean_stb_i  input  1  one-cycle strobe that clears sent_cnt_o.

Function
REQ-022 SHALL implement FSM IDLE/SEND; str_ready_o=1 only in IDLE.
REQ-023 In IDLE, on str_valid_i&&str_ready_o SHALL latch data and length.
- If length is 1..MAX_STR_SIZE, go to SEND with beat index 0.
- If length is 0 or >MAX_STR_SIZE, discard the string and stay in IDLE.
REQ-024 ast_source_valid_o SHALL be registered; it goes high the cycle after acceptance and stays high throughout SEND.
REQ-025 Packet SHALL have N=ceil(len/AST_SOURCE_SYMBOLS) beats; beat k carries string bytes k*S..k*S+S-1 (S=AST_SOURCE_SYMBOLS).
REQ-026 Symbol placement:
- ORDER=1: symbol j of a beat sits in data element S-1-j.
- ORDER=0: symbol j sits in data element j.
- Positions beyond len SHALL be driven 0.
REQ-027 sop SHALL be 1 on beat 0 only, eop 1 on beat N-1 only (both 1 when N=1).
REQ-028 On the eop beat, empty SHALL be S*N-len; on all other beats it SHALL be 0.
REQ-029 Beat index SHALL advance only on valid&&ready; while ready is low, data/sop/eop/empty/valid SHALL hold stable.
REQ-030 Acceptance of the eop beat SHALL return the FSM to IDLE; valid_o=0 the following cycle, str_ready_o=1.

Reset
REQ-031 While srst_n_i=0, sampled at clk_i, the block SHALL apply these values:
- FSM=IDLE, beat index 0.
- valid/sop/eop=0, data=0, empty=0.
- sent_cnt_o=0.
REQ-032 Reset asserted mid-packet SHALL abort the packet; no further beats are emitted.

Configuration
REQ-033 Macro SUSPECT_STR_AST_TX_CNT_EN, when defined, SHALL compile in the packet counter:
- sent_cnt_o increments on every accepted eop beat and saturates at all-ones.
- sent_cnt_clean_stb_i clears it to 0; clear wins over a simultaneous increment.
REQ-034 When the macro is undefined, sent_cnt_o SHALL be constant 0 and sent_cnt_clean_stb_i ignored.

Verification (S=8, MAX_STR_SIZE=16, ORDER=1)
REQ-035 len=5 "ABCDE", ready=1 -> one beat:
- sop=eop=1, empty=3.
- data[7..3]="A".."E", data[2..0]=0.
REQ-036 len=16 -> two beats, sop on beat 0, eop on beat 1, empty=0, str_ready_o low for 2 cycles.
REQ-037 len=9, ready low 3 cycles during beat 1 -> beat 1 held stable, then eop, empty=7, data[7]=9th byte.
REQ-038 len=0, then len=17 -> no valid_o, str_ready_o stays 1, FSM stays in IDLE.
REQ-039 srst_n_i=0 for one cycle during beat 0 of a 2-beat packet -> valid_o=0 next cycle, no eop, then a new string is accepted normally.
REQ-040 With the macro defined, 3 packets give sent_cnt_o=3; the clean strobe coincident with the 4th eop gives 0. With the macro undefined, sent_cnt_o=0 throughout.
